sram_dual_arb: RTL and testbench

- Two-requester arbiter and sequencer in front of the 64 KB two-bank SRAM array (2 banks x 4 byte-lane 8 KB macros).
- Accepts byte/half/word commands from port A (AHB slave side) and port B (secondary master, e.g. DMA/BIST).
- Grants one command per cycle and decodes bank/lane chip-selects.
- Registers the SRAM command and returns masked, lane-aligned read data with fixed latency.

---
 rtl/sram_dual_arb_if.sv | 40 ++++
 rtl/sram_dual_arb.sv | 150 +++++++++++++++
 tb/tb_sram_dual_arb.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dual_arb_if.sv
// Requester-side bundle for the dual-port SRAM arbiter: A and B command/response.
// Master = requesters (AHB slave side, DMA/BIST), slave = arbiter.
// Commands held until gnt; responses are unconditional pulses.
interface sram_dual_arb_if #(
    parameter int AW = 16
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [1:0]    a_size;
    logic [31:0]   a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic          a_err;
    logic [31:0]   a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [1:0]    b_size;
    logic [31:0]   b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic          b_err;
    logic [31:0]   b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_size, a_wdata,
        output b_req, b_we, b_addr, b_size, b_wdata,
        input  a_gnt, a_rvalid, a_err, a_rdata,
        input  b_gnt, b_rvalid, b_err, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_size, a_wdata,
        input  b_req, b_we, b_addr, b_size, b_wdata,
        output a_gnt, a_rvalid, a_err, a_rdata,
        output b_gnt, b_rvalid, b_err, b_rdata
    );
endinterface

// File: rtl/sram_dual_arb.sv
// Two-requester arbiter/sequencer for the 2-bank x 4-lane SRAM array.
// Latency: gnt same cycle, SRAM command at +1, rvalid/rdata at +2.
// Backpressure: requester holds req until gnt; one grant per cycle, no bubbles.
module sram_dual_arb #(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 16
) (
    input  logic          hclk,
    input  logic          hresetn,
    sram_dual_arb_if.slave bus,
    output logic [AW-4:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic          sram_we,
    output logic [3:0]    bank0_cs,
    output logic [3:0]    bank1_cs,
    input  logic [7:0]    sram_b0,
    input  logic [7:0]    sram_b1,
    input  logic [7:0]    sram_b2,
    input  logic [7:0]    sram_b3,
    input  logic [7:0]    sram_b4,
    input  logic [7:0]    sram_b5,
    input  logic [7:0]    sram_b6,
    input  logic [7:0]    sram_b7
);

    logic          prefer_a;
    logic          a_win;
    logic          gnt_any;
    logic          sel_b;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_size;
    logic [31:0]   cmd_wdata;
    logic          cmd_err;
    logic [3:0]    cmd_mask;

    logic          s1_vld, s1_id, s1_rd, s1_bank, s1_err;
    logic [3:0]    s1_mask;
    logic          s2_vld, s2_id, s2_rd, s2_bank, s2_err;
    logic [3:0]    s2_mask;

    logic [31:0]   rd_word;
    logic [31:0]   resp_data;

    // Grants are forced low while reset is asserted so nothing is accepted into a dead pipe.
    always_comb begin
        a_win     = bus.a_req && (!bus.b_req || (FIXED_PRIO != 0) || prefer_a);
        bus.a_gnt = hresetn && a_win;
        bus.b_gnt = hresetn && bus.b_req && !a_win;
        sel_b     = bus.b_gnt;
        gnt_any   = bus.a_gnt || bus.b_gnt;
        cmd_we    = sel_b ? bus.b_we    : bus.a_we;
        cmd_addr  = sel_b ? bus.b_addr  : bus.a_addr;
        cmd_size  = sel_b ? bus.b_size  : bus.a_size;
        cmd_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
    end

    // Lane mask from size/offset; illegal commands get an empty mask.
    always_comb begin
        cmd_err  = 1'b0;
        cmd_mask = 4'b0000;
        case (cmd_size)
            2'b00: cmd_mask = 4'b0001 << cmd_addr[1:0];
            2'b01: begin
                if (cmd_addr[0]) cmd_err  = 1'b1;
                else             cmd_mask = cmd_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                if (cmd_addr[1:0] != 2'b00) cmd_err  = 1'b1;
                else                        cmd_mask = 4'b1111;
            end
            default: cmd_err = 1'b1;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            prefer_a <= 1'b1;
        end else if (gnt_any) begin
            prefer_a <= sel_b;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s1_vld     <= 1'b0;
            s1_id      <= 1'b0;
            s1_rd      <= 1'b0;
            s1_bank    <= 1'b0;
            s1_err     <= 1'b0;
            s1_mask    <= 4'b0000;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            bank0_cs   <= 4'b0000;
            bank1_cs   <= 4'b0000;
        end else begin
            s1_vld   <= gnt_any;
            sram_we  <= gnt_any && cmd_we;
            bank0_cs <= (gnt_any && !cmd_addr[AW-1]) ? cmd_mask : 4'b0000;
            bank1_cs <= (gnt_any &&  cmd_addr[AW-1]) ? cmd_mask : 4'b0000;
            if (gnt_any) begin
                sram_addr  <= cmd_addr[AW-2:2];
                sram_wdata <= cmd_wdata;
                s1_id      <= sel_b;
                s1_rd      <= !cmd_we;
                s1_bank    <= cmd_addr[AW-1];
                s1_err     <= cmd_err;
                s1_mask    <= cmd_mask;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s2_vld  <= 1'b0;
            s2_id   <= 1'b0;
            s2_rd   <= 1'b0;
            s2_bank <= 1'b0;
            s2_err  <= 1'b0;
            s2_mask <= 4'b0000;
        end else begin
            s2_vld  <= s1_vld;
            s2_id   <= s1_id;
            s2_rd   <= s1_rd;
            s2_bank <= s1_bank;
            s2_err  <= s1_err;
            s2_mask <= s1_mask;
        end
    end

    // Macro outputs are valid in S2; only the lanes this command selected are passed.
    always_comb begin
        rd_word   = s2_bank ? {sram_b7, sram_b6, sram_b5, sram_b4}
                            : {sram_b3, sram_b2, sram_b1, sram_b0};
        resp_data = 32'h0;
        if (s2_rd && !s2_err) begin
            for (int l = 0; l < 4; l++) begin
                if (s2_mask[l]) resp_data[8*l +: 8] = rd_word[8*l +: 8];
            end
        end
        bus.a_rvalid = s2_vld && !s2_id;
        bus.b_rvalid = s2_vld &&  s2_id;
        bus.a_err    = bus.a_rvalid && s2_err;
        bus.b_err    = bus.b_rvalid && s2_err;
        bus.a_rdata  = bus.a_rvalid ? resp_data : 32'h0;
        bus.b_rdata  = bus.b_rvalid ? resp_data : 32'h0;
    end

endmodule

// File: tb/tb_sram_dual_arb.sv
// Bench for sram_dual_arb: directed scenarios plus randomized two-port traffic,
// checked against a byte-addressed reference memory and a response queue.
module tb_sram_dual_arb;

    logic        hclk;
    logic        hresetn;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic [3:0]  bank0_cs;
    logic [3:0]  bank1_cs;
    logic [7:0]  sram_rd [0:7];
    logic [7:0]  sram_mem [0:65535];

    sram_dual_arb_if #(.AW(16)) bus ();

    sram_dual_arb #(.FIXED_PRIO(0), .AW(16)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .bank0_cs   (bank0_cs),
        .bank1_cs   (bank1_cs),
        .sram_b0    (sram_rd[0]),
        .sram_b1    (sram_rd[1]),
        .sram_b2    (sram_rd[2]),
        .sram_b3    (sram_rd[3]),
        .sram_b4    (sram_rd[4]),
        .sram_b5    (sram_rd[5]),
        .sram_b6    (sram_rd[6]),
        .sram_b7    (sram_rd[7])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Synchronous SRAM macros: registered read data, write at the clock edge ending S1.
    always @(posedge hclk) begin
        for (int l = 0; l < 4; l++) begin
            if (bank0_cs[l]) begin
                if (sram_we) sram_mem[{1'b0, sram_addr, l[1:0]}] <= sram_wdata[8*l +: 8];
                else         sram_rd[l] <= sram_mem[{1'b0, sram_addr, l[1:0]}];
            end
            if (bank1_cs[l]) begin
                if (sram_we) sram_mem[{1'b1, sram_addr, l[1:0]}] <= sram_wdata[8*l +: 8];
                else         sram_rd[4+l] <= sram_mem[{1'b1, sram_addr, l[1:0]}];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        port;
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    logic [7:0]  ref_mem [0:65535];
    int          cyc = 0;
    logic        pref_a = 1'b1;
    logic        es_v = 1'b0;
    logic [3:0]  es_cs0 = 4'h0, es_cs1 = 4'h0;
    logic        es_we = 1'b0;
    logic [12:0] es_addr = '0;
    logic [31:0] es_wd = '0;

    function automatic void model_cmd(input logic [15:0] addr, input logic [1:0] size,
                                      output logic err, output logic [3:0] mask);
        int off;
        off  = int'(addr) % 4;
        err  = 1'b0;
        mask = 4'h0;
        if (size == 2'd0)                       mask = 4'(1 << off);
        else if (size == 2'd1 && off % 2 == 0)  mask = (off == 2) ? 4'hC : 4'h3;
        else if (size == 2'd2 && off == 0)      mask = 4'hF;
        else                                    err  = 1'b1;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        for (int i = 0; i < 8; i++) sram_rd[i] = 8'h00;
    end

    initial begin
        resp_t       r;
        logic        ga, gb, c_we, c_err;
        logic [15:0] c_addr;
        logic [1:0]  c_size;
        logic [31:0] c_wdata, c_data;
        logic [3:0]  c_mask;
        logic        ea_v, eb_v, ea_e, eb_e;
        logic [31:0] ea_d, eb_d;
        int          idx;
        forever begin
            @(negedge hclk);
            cyc++;
            if (!hresetn) begin
                check("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
                check("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
                check("rst_cs0", 32'(bank0_cs), 32'd0);
                check("rst_cs1", 32'(bank1_cs), 32'd0);
                check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
                check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
                rq.delete();
                es_v = 1'b0; es_cs0 = 4'h0; es_cs1 = 4'h0; es_we = 1'b0;
                pref_a = 1'b1;
            end else begin
                ea_v = 0; eb_v = 0; ea_e = 0; eb_e = 0; ea_d = 0; eb_d = 0;
                if (rq.size() != 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    if (r.port) begin eb_v = 1; eb_e = r.err; eb_d = r.data; end
                    else        begin ea_v = 1; ea_e = r.err; ea_d = r.data; end
                end
                check("a_rvalid", 32'(bus.a_rvalid), 32'(ea_v));
                check("b_rvalid", 32'(bus.b_rvalid), 32'(eb_v));
                check("a_err", 32'(bus.a_err), 32'(ea_e));
                check("b_err", 32'(bus.b_err), 32'(eb_e));
                check("a_rdata", bus.a_rdata, ea_d);
                check("b_rdata", bus.b_rdata, eb_d);

                check("s1_cs0", 32'(bank0_cs), 32'(es_cs0));
                check("s1_cs1", 32'(bank1_cs), 32'(es_cs1));
                check("s1_we", 32'(sram_we), 32'(es_we));
                if (es_v) begin
                    check("s1_addr", 32'(sram_addr), 32'(es_addr));
                    check("s1_wdata", sram_wdata, es_wd);
                end

                ga = bus.a_req && (!bus.b_req || pref_a);
                gb = bus.b_req && !ga;
                check("a_gnt", 32'(bus.a_gnt), 32'(ga));
                check("b_gnt", 32'(bus.b_gnt), 32'(gb));
                es_v = ga || gb;
                es_cs0 = 4'h0; es_cs1 = 4'h0; es_we = 1'b0;
                if (es_v) begin
                    c_we    = gb ? bus.b_we    : bus.a_we;
                    c_addr  = gb ? bus.b_addr  : bus.a_addr;
                    c_size  = gb ? bus.b_size  : bus.a_size;
                    c_wdata = gb ? bus.b_wdata : bus.a_wdata;
                    model_cmd(c_addr, c_size, c_err, c_mask);
                    c_data = 32'h0;
                    for (int l = 0; l < 4; l++) begin
                        idx = (int'(c_addr) / 4) * 4 + l;
                        if (c_mask[l]) begin
                            if (c_we) ref_mem[idx] = c_wdata[8*l +: 8];
                            else      c_data[8*l +: 8] = ref_mem[idx];
                        end
                    end
                    r.port = gb; r.due = cyc + 2; r.err = c_err; r.data = c_data;
                    rq.push_back(r);
                    es_cs0  = c_addr[15] ? 4'h0 : c_mask;
                    es_cs1  = c_addr[15] ? c_mask : 4'h0;
                    es_we   = c_we;
                    es_addr = c_addr[14:2];
                    es_wd   = c_wdata;
                    pref_a  = gb;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0]  t_cs0, t_cs1;
    logic [12:0] t_sa;
    logic        t_rv, t_er;
    logic [31:0] t_rd;

    task automatic run_a(input logic we, input logic [15:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
        int n;
        @(posedge hclk); #1;
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr;
        bus.a_size = size; bus.a_wdata = wdata;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!bus.a_gnt && n < 20);
        check("a_gnt_seen", 32'(bus.a_gnt), 32'd1);
        @(posedge hclk); #1;
        bus.a_req = 1'b0;
        @(negedge hclk);
        t_cs0 = bank0_cs; t_cs1 = bank1_cs; t_sa = sram_addr;
        @(negedge hclk);
        t_rv = bus.a_rvalid; t_er = bus.a_err; t_rd = bus.a_rdata;
    endtask

    task automatic rnd_cmd(output logic we, output logic [15:0] addr,
                           output logic [1:0] size, output logic [31:0] wdata);
        int s;
        we    = 1'($urandom_range(0, 1));
        addr  = 16'($urandom_range(0, 1) * 32768 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        s     = $urandom_range(0, 9);
        size  = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
        wdata = $urandom;
    endtask

    initial begin
        logic prev_a;
        hresetn = 1'b0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_size = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_size = 0; bus.b_wdata = 0;
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(negedge hclk);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_wdata", sram_wdata, 32'd0);
        check("rst_sram_we", 32'(sram_we), 32'd0);

        run_a(1'b1, 16'h0010, 2'b10, 32'h12345678);
        check("wr_cs0", 32'(t_cs0), 32'hF);
        check("wr_addr", 32'(t_sa), 32'h004);
        check("wr_rvalid", 32'(t_rv), 32'd1);
        run_a(1'b0, 16'h0010, 2'b10, 32'h0);
        check("rd_data", t_rd, 32'h12345678);
        check("rd_err", 32'(t_er), 32'd0);
        check("rd_cs0", 32'(t_cs0), 32'hF);
        check("rd_addr", 32'(t_sa), 32'h004);

        run_a(1'b1, 16'h8003, 2'b00, 32'hAB000000);
        check("bwr_cs1", 32'(t_cs1), 32'h8);
        check("bwr_cs0", 32'(t_cs0), 32'h0);
        run_a(1'b0, 16'h8000, 2'b10, 32'h0);
        check("bwr_lane3", 32'(t_rd[31:24]), 32'hAB);

        run_a(1'b0, 16'h0002, 2'b01, 32'h0);
        check("half_cs0", 32'(t_cs0), 32'hC);
        check("half_lo", 32'(t_rd[15:0]), 32'h0);

        run_a(1'b0, 16'h0001, 2'b10, 32'h0);
        check("mis_cs", 32'({t_cs1, t_cs0}), 32'h0);
        check("mis_err", 32'(t_er), 32'd1);
        check("mis_rdata", t_rd, 32'h0);
        run_a(1'b1, 16'h8000, 2'b11, 32'hFFFFFFFF);
        check("ill_cs", 32'({t_cs1, t_cs0}), 32'h0);
        check("ill_err", 32'(t_er), 32'd1);
        check("ill_rdata", t_rd, 32'h0);

        // Both ports requesting continuously: grants must alternate.
        @(posedge hclk); #1;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0010; bus.a_size = 2'b10;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h8000; bus.b_size = 2'b10;
        prev_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hclk);
            check("alt_one_gnt", 32'(bus.a_gnt ^ bus.b_gnt), 32'd1);
            if (i > 0) check("alt_order", 32'(bus.a_gnt), 32'(!prev_a));
            prev_a = bus.a_gnt;
        end
        @(posedge hclk); #1;
        bus.a_req = 0; bus.b_req = 0;
        repeat (3) @(negedge hclk);

        // Reset while a read sits in S1.
        @(posedge hclk); #1;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0010; bus.a_size = 2'b10;
        @(negedge hclk);
        check("rst_rd_gnt", 32'(bus.a_gnt), 32'd1);
        @(posedge hclk); #1;
        hresetn = 1'b0;
        @(negedge hclk);
        check("rst_s1_cs0", 32'(bank0_cs), 32'd0);
        check("rst_req_gnt", 32'(bus.a_gnt), 32'd0);
        bus.a_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            check("rst_no_rvalid", 32'(bus.a_rvalid), 32'd0);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(negedge hclk);
        check("post_rst_rvalid", 32'(bus.a_rvalid), 32'd0);
        run_a(1'b0, 16'h0010, 2'b10, 32'h0);
        check("post_rst_rd", t_rd, 32'h12345678);
        check("post_rst_rv", 32'(t_rv), 32'd1);

        fork
            begin : drv_a
                logic g, we; logic [15:0] ad; logic [1:0] sz; logic [31:0] wd;
                for (int c = 0; c < 1500; c++) begin
                    @(negedge hclk); g = bus.a_gnt;
                    @(posedge hclk); #1;
                    if (bus.a_req && !g && $urandom_range(0, 15) == 0) bus.a_req = 0;
                    else if (!bus.a_req || g) begin
                        rnd_cmd(we, ad, sz, wd);
                        bus.a_req = ($urandom_range(0, 3) != 0);
                        bus.a_we = we; bus.a_addr = ad; bus.a_size = sz; bus.a_wdata = wd;
                    end
                end
                bus.a_req = 0;
            end
            begin : drv_b
                logic g, we; logic [15:0] ad; logic [1:0] sz; logic [31:0] wd;
                for (int c = 0; c < 1500; c++) begin
                    @(negedge hclk); g = bus.b_gnt;
                    @(posedge hclk); #1;
                    if (bus.b_req && !g && $urandom_range(0, 15) == 0) bus.b_req = 0;
                    else if (!bus.b_req || g) begin
                        rnd_cmd(we, ad, sz, wd);
                        bus.b_req = ($urandom_range(0, 3) != 0);
                        bus.b_we = we; bus.b_addr = ad; bus.b_size = sz; bus.b_wdata = wd;
                    end
                end
                bus.b_req = 0;
            end
        join

        repeat (5) @(negedge hclk);
        check("drain", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
